// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one variable-latency unified memory between the fetch
//               and data ports, with a fetch/data stall and an access timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_ack_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ack_o,
   output logic              err_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              stall_o
);

   localparam int               CNT_W          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_d_want;
   logic             w_i_want;
   logic             w_tout;

   // A port acked this cycle was satisfied at this edge and must not be re-granted.
   assign w_d_want = d_req_i  & ~d_ack_o;
   assign w_i_want = if_req_i & ~if_ack_o;
   assign w_tout   = ~mem_ready_i & (r_cnt == c_TIMEOUT_LAST);
   assign stall_o  = w_i_want | w_d_want;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_d_want)      w_state_nxt = ST_BUSY_D;
            else if (w_i_want) w_state_nxt = ST_BUSY_I;
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (mem_ready_i || w_tout) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt       <= '0;
         if_data_o   <= '0;
         d_rdata_o   <= '0;
         if_ack_o    <= 1'b0;
         d_ack_o     <= 1'b0;
         err_o       <= 1'b0;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         if_ack_o <= 1'b0;
         d_ack_o  <= 1'b0;
         err_o    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_d_want) begin
                  mem_en_o    <= 1'b1;
                  mem_we_o    <= d_we_i;
                  mem_addr_o  <= d_addr_i;
                  mem_wdata_o <= d_wdata_i;
               end else if (w_i_want) begin
                  mem_en_o   <= 1'b1;
                  mem_we_o   <= 1'b0;
                  mem_addr_o <= if_addr_i;
               end
            end
            ST_BUSY_I: begin
               if (mem_ready_i || w_tout) begin
                  if (mem_ready_i) if_data_o <= mem_rdata_i;
                  if_ack_o <= 1'b1;
                  err_o    <= ~mem_ready_i;
                  mem_en_o <= 1'b0;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_BUSY_D: begin
               if (mem_ready_i || w_tout) begin
                  // Stores leave the load-data register untouched.
                  if (mem_ready_i && !mem_we_o) d_rdata_o <= mem_rdata_i;
                  d_ack_o  <= 1'b1;
                  err_o    <= ~mem_ready_i;
                  mem_en_o <= 1'b0;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

`default_nettype wire
